// File: rtl/digit_scanner_pkg.sv
// Shared definitions for the digit scanner: state encodings, counter widths
// and the digit-advance rule.
`ifndef DIGIT_SCANNER_PKG_SV
`define DIGIT_SCANNER_PKG_SV
package digit_scanner_pkg;

  localparam int DWELL_W = 16;
  localparam int BLANK_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  // >= so that shrinking last_digit below the current digit wraps at once
  function automatic logic [2:0] next_sel(input logic [2:0] cur, input logic [2:0] last);
    return (cur >= last) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage
`endif

// File: rtl/digit_scanner_counter.sv
// Up-counter with synchronous clear and a terminal-count flag.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_terminal,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_en)
      r_count <= r_count + W'(1);
  end

  assign o_tc = (r_count == i_terminal);

endmodule

// File: rtl/digit_scanner.sv
// Multiplexed display scanner: dwells PRESCALE cycles on each digit, blanks for
// BLANK_CYCLES cycles, then advances, wrapping after last_digit.
//
// state | meaning
// IDLE  | scan stopped, digit 0 selected, outputs blanked
// SHOW  | current digit driven, dwell counter running
// BLANK | decoder gated off between digits, blank counter running
module digit_scanner
  import digit_scanner_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  last_digit,
  input  logic [31:0] data,
  output logic [2:0]  sel,
  output logic [3:0]  nibble,
  output logic        blank,
  output logic        frame_done
);

  localparam logic [DWELL_W-1:0] DWELL_TC = DWELL_W'(PRESCALE - 1);
  localparam logic [BLANK_W-1:0] BLANK_TC =
    (BLANK_CYCLES == 0) ? '0 : BLANK_W'(BLANK_CYCLES - 1);
  localparam bit NO_BLANK = (BLANK_CYCLES == 0);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_sel;
  logic       r_frame_done;
  logic       w_dwell_clr, w_dwell_en, w_dwell_tc;
  logic       w_blank_clr, w_blank_en, w_blank_tc;
  logic       w_advance;

  mod_counter #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst        (reset),
    .i_clr      (w_dwell_clr),
    .i_en       (w_dwell_en),
    .i_terminal (DWELL_TC),
    .o_tc       (w_dwell_tc)
  );

  mod_counter #(.W(BLANK_W)) u_blank (
    .clk        (clk),
    .rst        (reset),
    .i_clr      (w_blank_clr),
    .i_en       (w_blank_en),
    .i_terminal (BLANK_TC),
    .o_tc       (w_blank_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Counters are held clear except while counting inside their own state,
  // so each state entry starts from zero and neither counter can wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_dwell_clr = 1'b1;
    w_dwell_en  = 1'b0;
    w_blank_clr = 1'b1;
    w_blank_en  = 1'b0;
    w_advance   = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = SHOW;
        SHOW: begin
          if (w_dwell_tc) begin
            if (NO_BLANK)
              w_advance = 1'b1;
            else
              w_state_nxt = BLANK;
          end else begin
            w_dwell_clr = 1'b0;
            w_dwell_en  = 1'b1;
          end
        end
        BLANK: begin
          if (w_blank_tc) begin
            w_advance   = 1'b1;
            w_state_nxt = SHOW;
          end else begin
            w_blank_clr = 1'b0;
            w_blank_en  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel        <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!enable || r_state == IDLE) begin
        r_sel <= 3'd0;
      end else if (w_advance) begin
        r_sel        <= next_sel(r_sel, last_digit);
        r_frame_done <= (r_sel >= last_digit);
      end
    end
  end

  assign sel        = r_sel;
  assign nibble     = data[{r_sel, 2'b00} +: 4];
  assign blank      = (r_state != SHOW);
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_digit_scanner.sv
// Self-checking bench: two scanners (blanking 2 and blanking 0) checked every
// cycle against a period-position reference model.
module tb_digit_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, enable2;
  logic [2:0]  last_digit, ld2;
  logic [31:0] data, data2;
  logic [2:0]  sel1, sel2;
  logic [3:0]  nib1, nib2;
  logic        blank1, blank2, fd1, fd2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: position within the digit period, current digit, pulse
  int m_t[2];
  int m_sel[2];
  bit m_act[2];
  bit m_fd[2];
  int m_p[2] = '{4, 4};
  int m_b[2] = '{2, 0};

  always #5 clk = ~clk;

  digit_scanner #(.PRESCALE(4), .BLANK_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .last_digit(last_digit),
    .data(data), .sel(sel1), .nibble(nib1), .blank(blank1), .frame_done(fd1));

  digit_scanner #(.PRESCALE(4), .BLANK_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2), .last_digit(ld2),
    .data(data2), .sel(sel2), .nibble(nib2), .blank(blank2), .frame_done(fd2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_idle();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_sel[i] = 0; m_fd[i] = 0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      bit en;
      int ld;
      en = (i == 0) ? enable : enable2;
      ld = (i == 0) ? int'(last_digit) : int'(ld2);
      if (reset || !en) begin
        m_act[i] = 0; m_t[i] = 0; m_sel[i] = 0; m_fd[i] = 0;
      end else if (!m_act[i]) begin
        m_act[i] = 1; m_t[i] = 0; m_fd[i] = 0;
      end else begin
        m_fd[i] = 0;
        m_t[i]++;
        if (m_t[i] == m_p[i] + m_b[i]) begin
          m_t[i] = 0;
          if (m_sel[i] >= ld) begin
            m_sel[i] = 0;
            m_fd[i]  = 1;
          end else begin
            m_sel[i]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] d;
    bit          eb;
    eb = !m_act[0] || (m_t[0] >= m_p[0]);
    d  = data >> (4 * m_sel[0]);
    chk("sel1", 32'(sel1), 32'(m_sel[0]));
    chk("nibble1", 32'(nib1), 32'(d[3:0]));
    chk("blank1", 32'(blank1), 32'(eb));
    chk("frame_done1", 32'(fd1), 32'(m_fd[0]));
    eb = !m_act[1] || (m_t[1] >= m_p[1]);
    d  = data2 >> (4 * m_sel[1]);
    chk("sel2", 32'(sel2), 32'(m_sel[1]));
    chk("nibble2", 32'(nib2), 32'(d[3:0]));
    chk("blank2", 32'(blank2), 32'(eb));
    chk("frame_done2", 32'(fd2), 32'(m_fd[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic timeout(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: wait expired", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int pulses;
    bit ok;

    reset      = 1'b1;
    enable     = 1'b0;
    enable2    = 1'b0;
    last_digit = 3'd7;
    ld2        = 3'd0;
    data       = 32'h76543210;
    data2      = $urandom;
    model_idle();
    #1;
    check_all();
    tick();
    tick();
    reset   = 1'b0;
    enable  = 1'b1;
    enable2 = 1'b1;

    // full scans of all eight digits, nibble tracks sel
    for (int c = 0; c < 110; c++) tick();

    // lower last_digit while digit 5 is showing: next advance wraps
    ok = 0;
    for (guard = 0; guard < 100; guard++) begin
      if (m_act[0] && m_sel[0] == 5 && m_t[0] == 0) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("wait_sel5");
    last_digit = 3'd2;
    ok = 0;
    for (guard = 0; guard < 20; guard++) begin
      tick();
      if (sel1 != 3'd5) begin ok = 1; break; end
    end
    if (!ok) timeout("wait_wrap");
    chk("wrap_sel", 32'(sel1), 32'd0);
    chk("wrap_frame_done", 32'(fd1), 32'd1);

    // drop enable during BLANK on digit 3, then re-enable
    last_digit = 3'd7;
    ok = 0;
    for (guard = 0; guard < 100; guard++) begin
      if (m_act[0] && m_sel[0] == 3 && m_t[0] == m_p[0]) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("wait_blank3");
    chk("blank_at_drop", 32'(blank1), 32'd1);
    enable = 1'b0;
    tick();
    chk("drop_sel", 32'(sel1), 32'd0);
    chk("drop_blank", 32'(blank1), 32'd1);
    enable = 1'b1;
    for (int c = 0; c < 8; c++) tick();

    // asynchronous reset pulse between edges while digit 2 is showing
    ok = 0;
    for (guard = 0; guard < 100; guard++) begin
      if (m_act[0] && m_sel[0] == 2 && m_t[0] == 1) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("wait_show2");
    #1 reset = 1'b1;
    #1;
    model_idle();
    chk("async_rst_sel", 32'(sel1), 32'd0);
    chk("async_rst_blank", 32'(blank1), 32'd1);
    chk("async_rst_fd", 32'(fd1), 32'd0);
    check_all();
    #1 reset = 1'b0;
    for (int c = 0; c < 20; c++) tick();

    // zero-blank scanner on digit 0 only: pulse every 4 cycles, never blank
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (fd2) pulses++;
      if (blank2) pulses += 100;
    end
    chk("noblank_pulses", 32'(pulses), 32'd10);

    // randomized data, last_digit changes and short enable drops
    for (int c = 0; c < 400; c++) begin
      data  = $urandom;
      data2 = $urandom;
      if ($urandom_range(0, 24) == 0) last_digit = 3'($urandom_range(0, 7));
      if (!enable) enable = 1'b1;
      else if ($urandom_range(0, 59) == 0) enable = 1'b0;
      if ($urandom_range(0, 99) == 0) enable2 = ~enable2;
      #1 check_all();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
